cpu_bus_map: RTL and testbench
==============================

Name: cpu_bus_map

Overview:
- Synthesizable, parametrised CPU-side address decoder and memory subsystem for the 6502 core, replacing the behavioural memory model.
- Decodes the 16-bit CPU bus into the following targets:
  - internal work RAM, mirrored;
  - internal battery SRAM;
  - external PRG ROM port;
  - PPU register port, mirrored every 8 bytes;
  - N serial joypads.
- Adds a $4014 sprite DMA engine that stalls the CPU and streams one 256-byte page into PPU $2004.

Parameters:
- RAM_AW, 11, work-RAM address width; RAM is mirrored across $0000-$1FFF.
- SRAM_AW, 13, SRAM address width at $6000-$7FFF.
- PRG_AW, 15, PRG ROM address width at $8000-$FFFF.
- NUM_PADS, 2, number of joypads (1..2), mapped at $4016 and $4017.
- DMA_LEN, 256, bytes per sprite DMA transfer.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- addr_out  in  16  CPU address
- data_out  in  8  CPU write data
- ren  in  1  CPU read strobe
- wen  in  1  CPU write strobe
- data_in  out  8  CPU read data (combinational)
- rdy  out  1  CPU may advance; 0 during DMA
- prg_addr  out  PRG_AW  PRG ROM address
- prg_data  in  8  PRG ROM data (combinational)
- ppu_reg  out  3  PPU register index
- ppu_wen  out  1  PPU register write
- ppu_ren  out  1  PPU register read
- ppu_wdata  out  8  PPU write data
- ppu_rdata  in  8  PPU read data
- pad_buttons  in  8*NUM_PADS  live button state, pad k in bits [8k+7:8k], bit0=A..bit7=Right
- err  out  1  sticky illegal-access flag

Behaviour:
- Decode on addr_out[15:13]:
  - 1xx: PRG ROM at addr[PRG_AW-1:0].
  - 000: RAM at addr[RAM_AW-1:0].
  - 011: SRAM at addr[SRAM_AW-1:0].
  - 001: PPU, with ppu_reg = addr[2:0].
  - 010: IO at exact addresses $4014, $4016, $4017.
- Reads are combinational: data_in = selected source when ren=1, else 8'h00.
- Unmapped IO reads return 8'h00 and set err.
- Writes commit on posedge clk when wen=1 and rdy=1.
- A write to PRG ROM, or to an unmapped IO address, is dropped and sets err.
- err clears only on rst.
- ppu_wen/ppu_ren are combinational and asserted only while rdy=1 (CPU path) or by the DMA engine.
- Joypads:
  - A write to $4016 latches data_out[0] into strobe (shared by all pads).
  - While strobe=1, each shift reg reloads from pad_buttons every cycle, and reads return the live bit0 (A).
  - While strobe=0, a read of $4016+k returns {7'b0100000, sr_k[0]}; on the posedge with ren=1 the register shifts right, filling with 1.
  - After 8 reads, reads return 1.
  - A read of $4017 with NUM_PADS=1 returns {7'b0100000,1'b0} (no pad).
- DMA FSM, states IDLE, ALIGN, RD, WR:
  - IDLE: a write to $4014 latches page=data_out and sets cnt=0; next state ALIGN; rdy=0 from the following cycle.
  - ALIGN: 1 dummy cycle, then RD.
  - RD: internal read of {page,cnt[7:0]} through the same decode (no ppu_ren side effects on a $2xxx source: value 8'h00), latched into dbuf; then WR.
  - WR: ppu_reg=3'd4, ppu_wen=1, ppu_wdata=dbuf, cnt++. If cnt==DMA_LEN-1 go to IDLE, else RD.
  - Total stall = 1 + 2*DMA_LEN cycles (513 at default).
  - rdy returns to 1 the cycle after the final WR.
  - CPU ren/wen are ignored while rdy=0: data_in=8'h00 and there are no side effects, including joypad shifts.
  - A $4014 write during DMA cannot occur (rdy=0); the engine does not retrigger.
- Reset (synchronous): all RAM and SRAM words are 0, strobe=0, pad shift regs=8'hFF, state=IDLE, cnt=0, page=0, rdy=1, err=0.
- All PPU strobes are 0 during rst.
- rst asserted mid-DMA aborts the transfer immediately; rdy=1 next cycle.
- Address wrap: the DMA page index wraps within the page (cnt is 8 bits for the address). Page $FF reads $FF00-$FFFF from PRG.

Test Plan:
- Write 8'hA5 to $0001, read $0801, $1001, $1801 -> each returns 8'hA5. Write to $8000 -> err=1, subsequent read of $8000 = prg_data.
- Write $6123=8'h3C, read back 8'h3C. Read $2002 with ppu_rdata=8'h80 -> data_in=8'h80, ppu_ren=1, ppu_reg=2. Read $3FFA -> ppu_reg=2.
- pad_buttons[7:0]=8'b1000_0101, write $4016=1 then 0, do 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1,1,1, upper bits always 0100000.
- Fill RAM $0200-$02FF with i^8'h5A, write $4014=8'h02 -> rdy low for exactly 513 cycles, 256 ppu_wen pulses with ppu_reg=4 and data i^8'h5A in order.
- Assert rst at DMA byte 100 -> ppu_wen stops, rdy=1 next cycle, RAM reads 0, err=0.
- CPU issues wen to $0010 while rdy=0 -> RAM[$0010] unchanged after DMA completes.

Source files
------------

// File: rtl/cpu_bus_map.sv
// CPU-side address decoder for the 6502: mirrored work RAM, battery SRAM, PRG ROM port,
// mirrored PPU register port, serial joypads and the $4014 sprite DMA engine.
module cpu_bus_map #(
  parameter int RAM_AW   = 11,
  parameter int SRAM_AW  = 13,
  parameter int PRG_AW   = 15,
  parameter int NUM_PADS = 2,
  parameter int DMA_LEN  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           addr_out,
  input  logic [7:0]            data_out,
  input  logic                  ren,
  input  logic                  wen,
  output logic [7:0]            data_in,
  output logic                  rdy,
  output logic [PRG_AW-1:0]     prg_addr,
  input  logic [7:0]            prg_data,
  output logic [2:0]            ppu_reg,
  output logic                  ppu_wen,
  output logic                  ppu_ren,
  output logic [7:0]            ppu_wdata,
  input  logic [7:0]            ppu_rdata,
  input  logic [8*NUM_PADS-1:0] pad_buttons,
  output logic                  err,
  output logic [1:0]            dma_state
);

  localparam int CNT_W = $clog2(DMA_LEN) + 1;

  // Handshake: the CPU owns the bus only while rdy=1; ren/wen seen with rdy=0 have no effect.
  typedef enum logic [1:0] {IDLE, ALIGN, RD, WR} state_t;

  state_t           state, state_nx;
  logic [7:0]       page;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       dbuf;

  logic [7:0] ram  [2**RAM_AW];
  logic [7:0] sram [2**SRAM_AW];

  logic       strobe;
  logic [7:0] sr [NUM_PADS];
  logic [1:0] pad_hit, pad_bit;

  logic [15:0] bus_addr;
  logic sel_prg, sel_ram, sel_sram, sel_ppu, sel_io, io_ok;
  logic cpu_rd, cpu_wr, dma_go;
  logic [7:0] mem_val;

  // The DMA engine borrows the decoder only during RD; otherwise the CPU address drives it.
  assign bus_addr = (state == RD) ? {page, cnt[7:0]} : addr_out;

  assign sel_prg  = bus_addr[15];
  assign sel_ram  = (bus_addr[15:13] == 3'b000);
  assign sel_ppu  = (bus_addr[15:13] == 3'b001);
  assign sel_io   = (bus_addr[15:13] == 3'b010);
  assign sel_sram = (bus_addr[15:13] == 3'b011);
  assign pad_hit  = {bus_addr == 16'h4017, bus_addr == 16'h4016};
  assign io_ok    = (bus_addr == 16'h4014) || (|pad_hit);

  assign rdy       = (state == IDLE);
  assign dma_state = state;
  assign cpu_rd    = ren && rdy;
  assign cpu_wr    = wen && rdy;
  assign dma_go    = cpu_wr && (bus_addr == 16'h4014);

  assign prg_addr  = bus_addr[PRG_AW-1:0];
  assign ppu_reg   = (state == WR) ? 3'd4 : bus_addr[2:0];
  assign ppu_wdata = (state == WR) ? dbuf : data_out;
  assign ppu_wen   = !rst && ((state == WR) || (cpu_wr && sel_ppu));
  assign ppu_ren   = !rst && cpu_rd && sel_ppu;

  always_comb begin
    pad_bit = '0;
    for (int k = 0; k < NUM_PADS; k++)
      pad_bit[k] = strobe ? pad_buttons[8*k] : sr[k][0];
  end

  // Side-effect-free read mux; PPU space reads as zero here so DMA never strobes the PPU.
  always_comb begin
    mem_val = 8'h00;
    if (sel_prg)
      mem_val = prg_data;
    else if (sel_ram)
      mem_val = ram[bus_addr[RAM_AW-1:0]];
    else if (sel_sram)
      mem_val = sram[bus_addr[SRAM_AW-1:0]];
    else if (sel_io && pad_hit[0])
      mem_val = {7'b0100000, pad_bit[0]};
    else if (sel_io && pad_hit[1])
      mem_val = {7'b0100000, pad_bit[1]};
  end

  assign data_in = !cpu_rd ? 8'h00 : (sel_ppu ? ppu_rdata : mem_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**RAM_AW; i++) ram[i] <= 8'h00;
    end else if (cpu_wr && sel_ram) begin
      ram[bus_addr[RAM_AW-1:0]] <= data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2**SRAM_AW; i++) sram[i] <= 8'h00;
    end else if (cpu_wr && sel_sram) begin
      sram[bus_addr[SRAM_AW-1:0]] <= data_out;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((cpu_rd && sel_io && !io_ok) ||
                 (cpu_wr && (sel_prg || (sel_io && !io_ok)))) begin
      err <= 1'b1;
    end
  end

  // Reload takes priority over shifting while the strobe is held high.
  always_ff @(posedge clk) begin
    if (rst) begin
      strobe <= 1'b0;
      for (int k = 0; k < NUM_PADS; k++) sr[k] <= 8'hFF;
    end else begin
      if (cpu_wr && sel_io && pad_hit[0]) strobe <= data_out[0];
      for (int k = 0; k < NUM_PADS; k++) begin
        if (strobe)
          sr[k] <= pad_buttons[8*k +: 8];
        else if (cpu_rd && sel_io && pad_hit[k])
          sr[k] <= {1'b1, sr[k][7:1]};
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (dma_go) state_nx = ALIGN;
      ALIGN:   state_nx = RD;
      RD:      state_nx = WR;
      WR:      state_nx = (cnt == CNT_W'(DMA_LEN - 1)) ? IDLE : RD;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      page  <= 8'h00;
      cnt   <= '0;
      dbuf  <= 8'h00;
    end else begin
      state <= state_nx;
      if (dma_go) begin
        page <= data_out;
        cnt  <= '0;
      end
      if (state == RD) dbuf <= mem_val;
      if (state == WR) cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_bus_map.sv
// Directed bench for cpu_bus_map: memory map, joypad shifting, sprite DMA timing and reset abort.
module tb_cpu_bus_map;

  localparam int NUM_PADS = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [15:0]           addr_out;
  logic [7:0]            data_out;
  logic                  ren, wen;
  logic [7:0]            data_in;
  logic                  rdy;
  logic [14:0]           prg_addr;
  logic [7:0]            prg_data;
  logic [2:0]            ppu_reg;
  logic                  ppu_wen, ppu_ren;
  logic [7:0]            ppu_wdata, ppu_rdata;
  logic [8*NUM_PADS-1:0] pad_buttons;
  logic                  err;
  logic [1:0]            dma_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];

  cpu_bus_map #(.NUM_PADS(NUM_PADS)) dut (
    .clk(clk), .rst(rst), .addr_out(addr_out), .data_out(data_out),
    .ren(ren), .wen(wen), .data_in(data_in), .rdy(rdy),
    .prg_addr(prg_addr), .prg_data(prg_data), .ppu_reg(ppu_reg),
    .ppu_wen(ppu_wen), .ppu_ren(ppu_ren), .ppu_wdata(ppu_wdata),
    .ppu_rdata(ppu_rdata), .pad_buttons(pad_buttons), .err(err),
    .dma_state(dma_state)
  );

  always #5 clk = ~clk;

  // ROM model: byte at ROM offset a is a[7:0]^C3
  assign prg_data = prg_addr[7:0] ^ 8'hC3;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    addr_out = a; data_out = d; wen = 1'b1;
    @(posedge clk); @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d);
    addr_out = a; ren = 1'b1;
    #1 d = data_in;
    @(posedge clk); @(negedge clk);
    ren = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Trigger DMA and watch it; stop_after>0 returns at the negedge of that WR pulse.
  task automatic run_dma(input logic [7:0] page, input int stop_after,
                         output int low_cnt, output int pulses);
    logic [15:0] exp;
    bus_write(16'h4014, page);
    low_cnt = 0;
    pulses  = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (rdy) break;
      low_cnt++;
      if (ppu_wen) begin
        pulses++;
        check("dma_reg", 16'(ppu_reg), 16'd4);
        exp = (exp_q.size() != 0) ? 16'(exp_q.pop_front()) : 16'hFFFF;
        check("dma_data", 16'(ppu_wdata), exp);
      end
      if (pulses == stop_after) begin
        wen = 1'b0; ren = 1'b0;
        return;
      end
      addr_out = 16'h0010; data_out = 8'h77;
      wen = (cyc < 20); ren = (cyc < 20);
      #1 if (cyc < 20) check("stall_rdata", 16'(data_in), 16'h0000);
      @(negedge clk);
    end
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    int low_cnt, pulses, stray;
    int pad0_bits[10] = '{1, 0, 1, 0, 0, 0, 0, 1, 1, 1};
    int pad1_bits[3]  = '{0, 0, 1};

    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr_out = '0; data_out = '0;
    pad_buttons = '0; ppu_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_rdy", 16'(rdy), 16'd1);
    check("rst_err", 16'(err), 16'd0);
    check("rst_state", 16'(dma_state), 16'd0);
    check("rst_ppu_wen", 16'(ppu_wen), 16'd0);
    check("idle_data_in", 16'(data_in), 16'h00);
    bus_read(16'h0000, d); check("rst_ram", 16'(d), 16'h00);
    bus_read(16'h4016, d); check("rst_pad_sr", 16'(d), 16'h41);

    // RAM mirroring
    bus_write(16'h0001, 8'hA5);
    bus_read(16'h0801, d); check("ram_mirror_0801", 16'(d), 16'hA5);
    bus_read(16'h1001, d); check("ram_mirror_1001", 16'(d), 16'hA5);
    bus_read(16'h1801, d); check("ram_mirror_1801", 16'(d), 16'hA5);

    // PRG write is dropped and flags err
    bus_write(16'h8000, 8'h12);
    check("prg_wr_err", 16'(err), 16'd1);
    bus_read(16'h8000, d); check("prg_rd_8000", 16'(d), 16'hC3);
    bus_read(16'hFFFC, d); check("prg_rd_fffc", 16'(d), 16'h3F);

    // SRAM
    bus_write(16'h6123, 8'h3C);
    bus_read(16'h6123, d); check("sram_rd", 16'(d), 16'h3C);
    bus_read(16'h7123, d); check("sram_other", 16'(d), 16'h00);

    // PPU register port
    ppu_rdata = 8'h80;
    addr_out = 16'h2002; ren = 1'b1;
    #1;
    check("ppu_rdata", 16'(data_in), 16'h80);
    check("ppu_ren", 16'(ppu_ren), 16'd1);
    check("ppu_reg_2002", 16'(ppu_reg), 16'd2);
    @(posedge clk); @(negedge clk); ren = 1'b0;
    addr_out = 16'h3FFA; ren = 1'b1;
    #1 check("ppu_reg_3ffa", 16'(ppu_reg), 16'd2);
    @(posedge clk); @(negedge clk); ren = 1'b0;
    #1 check("ppu_ren_idle", 16'(ppu_ren), 16'd0);
    addr_out = 16'h2005; data_out = 8'h5E; wen = 1'b1;
    #1;
    check("ppu_wen", 16'(ppu_wen), 16'd1);
    check("ppu_reg_2005", 16'(ppu_reg), 16'd5);
    check("ppu_wdata", 16'(ppu_wdata), 16'h5E);
    @(posedge clk); @(negedge clk); wen = 1'b0;
    #1 check("ppu_wen_idle", 16'(ppu_wen), 16'd0);

    // Joypads: live bit while strobed, then serial shift
    pad_buttons = {8'h3C, 8'b1000_0101};
    bus_write(16'h4016, 8'h01);
    bus_read(16'h4016, d); check("pad_live_1", 16'(d), 16'h41);
    pad_buttons[0] = 1'b0;
    bus_read(16'h4016, d); check("pad_live_0", 16'(d), 16'h40);
    pad_buttons[0] = 1'b1;
    bus_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) begin
      bus_read(16'h4016, d);
      check($sformatf("pad0_bit%0d", i), 16'(d), 16'(8'h40 | 8'(pad0_bits[i])));
    end
    for (int i = 0; i < 3; i++) begin
      bus_read(16'h4017, d);
      check($sformatf("pad1_bit%0d", i), 16'(d), 16'(8'h40 | 8'(pad1_bits[i])));
    end

    // Sprite DMA from RAM page 2, with CPU writes attempted during the stall
    bus_write(16'h0010, 8'h11);
    for (int i = 0; i < 256; i++) begin
      bus_write({8'h02, 8'(i)}, 8'(i) ^ 8'h5A);
      exp_q.push_back(8'(i) ^ 8'h5A);
    end
    run_dma(8'h02, -1, low_cnt, pulses);
    check("dma_stall", 16'(low_cnt), 16'd513);
    check("dma_pulses", 16'(pulses), 16'd256);
    check("dma_q_left", 16'(exp_q.size()), 16'd0);
    bus_read(16'h0010, d); check("stall_wr_dropped", 16'(d), 16'h11);

    // DMA from PRG page $FF
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hC3);
    run_dma(8'hFF, -1, low_cnt, pulses);
    check("dma_ff_stall", 16'(low_cnt), 16'd513);
    check("dma_ff_pulses", 16'(pulses), 16'd256);

    // Reset during DMA byte 100
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'h5A);
    run_dma(8'h02, 100, low_cnt, pulses);
    check("abort_pulses", 16'(pulses), 16'd100);
    rst = 1'b1;
    #1 check("abort_rst_ppu_wen", 16'(ppu_wen), 16'd0);
    @(negedge clk);
    check("abort_rdy", 16'(rdy), 16'd1);
    rst = 1'b0;
    exp_q.delete();
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      if (ppu_wen) stray++;
      @(negedge clk);
    end
    check("abort_no_wen", 16'(stray), 16'd0);
    bus_read(16'h0200, d); check("abort_ram_0200", 16'(d), 16'h00);
    bus_read(16'h0010, d); check("abort_ram_0010", 16'(d), 16'h00);
    check("abort_err", 16'(err), 16'd0);

    // Unmapped IO and mapped-but-inert IO
    bus_read(16'h4015, d); check("io_unmapped_rd", 16'(d), 16'h00);
    check("io_unmapped_rd_err", 16'(err), 16'd1);
    pulse_rst();
    bus_write(16'h4020, 8'h55);
    check("io_unmapped_wr_err", 16'(err), 16'd1);
    pulse_rst();
    bus_write(16'h4017, 8'h55);
    check("io_4017_wr_no_err", 16'(err), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
